// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_REG_DATA_W = 32;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reservations set, writebacks clear, set wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                                clk,
  input  logic                                ares,
  input  logic [NUM_WR-1:0]                   we,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wa,
  input  logic                                rsv_en,
  input  logic [ADDR_WIDTH-1:0]               rsv_addr,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   ra,
  input  logic [NUM_RD-1:0]                   rd_hit,
  output logic [NUM_RD-1:0]                   rbusy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             rsv_ok;

  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  // Clears first, then the set, so a new producer overrides the retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NUM_WR; p++)
      if (we[p]) busy_nxt[wa[p]] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge ares) begin
    if (!ares) busy <= '0;
    else       busy <= busy_nxt;
  end

  // rd_hit is only ever set when bypass is enabled: forwarded data resolves the hazard.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++)
      rbusy[i] = busy[ra[i]] & ~rd_hit[i];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired x0, write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_DATA_W = DEF_REG_DATA_W,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           ares,
  input  logic [NUM_WR-1:0]              wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*REG_DATA_W-1:0]   wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*REG_DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]              rbusy,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic                           wr_clash
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa;
  logic [NUM_WR-1:0][REG_DATA_W-1:0] wd;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra;
  logic [NUM_RD-1:0][REG_DATA_W-1:0] rd;
  logic [NUM_WR-1:0]                 we;
  logic [NUM_RD-1:0]                 rd_hit;
  logic                              clash;
  logic [REG_DATA_W-1:0]             mem [DEPTH];

  assign wa    = waddr;
  assign wd    = wdata;
  assign ra    = raddr;
  assign rdata = rd;

  // Writes to x0 are dropped here so they neither store, bypass, clash nor clear busy.
  always_comb begin
    we = '0;
    for (int p = 0; p < NUM_WR; p++)
      we[p] = wen[p] && !(ZERO_REG != 0 && wa[p] == '0);
  end

  always_comb begin
    clash = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (we[p] && we[q] && wa[p] == wa[q]) clash = 1'b1;
  end

  // Ascending port order: the highest-index port's assignment lands last and wins.
  always_ff @(posedge clk or negedge ares) begin
    if (!ares) begin
      for (int i = 0; i < DEPTH; i++) mem[ADDR_WIDTH'(i)] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (we[p]) mem[wa[p]] <= wd[p];
    end
  end

  always_ff @(posedge clk or negedge ares) begin
    if (!ares) wr_clash <= 1'b0;
    else       wr_clash <= clash;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_DATA_W-1:0] val;
    logic                  hit;
    // Reset gating keeps bypass from leaking write data while ares is held.
    always_comb begin
      val = mem[ra[i]];
      hit = 1'b0;
      if (BYPASS != 0)
        for (int p = 0; p < NUM_WR; p++)
          if (we[p] && wa[p] == ra[i]) begin
            val = wd[p];
            hit = 1'b1;
          end
      if (ZERO_REG != 0 && ra[i] == '0) val = '0;
      if (!ares) val = '0;
    end
    assign rd[i]     = val;
    assign rd_hit[i] = hit;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .ares     (ares),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ra       (ra),
    .rd_hit   (rd_hit),
    .rbusy    (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 4R/2W bypassing instance and a 2R/1W non-bypassing instance side by side.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic ares;
  always #5 clk = ~clk;

  logic [1:0]       wen_a;
  logic [1:0][4:0]  waddr_a;
  logic [1:0][31:0] wdata_a;
  logic [3:0][4:0]  raddr_a;
  logic [3:0][31:0] rdata_a;
  logic [3:0]       rbusy_a;
  logic             rsv_en_a;
  logic [4:0]       rsv_addr_a;
  logic             wr_clash_a;

  logic [0:0]       wen_b;
  logic [4:0]       waddr_b;
  logic [31:0]      wdata_b;
  logic [1:0][4:0]  raddr_b;
  logic [1:0][31:0] rdata_b;
  logic [1:0]       rbusy_b;
  logic             rsv_en_b;
  logic [4:0]       rsv_addr_b;
  logic             wr_clash_b;

  regfile_mp #(.ADDR_WIDTH(5), .REG_DATA_W(32), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .ares(ares), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .raddr(raddr_a),
    .rdata(rdata_a), .rbusy(rbusy_a), .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a), .wr_clash(wr_clash_a));

  regfile_mp #(.ADDR_WIDTH(5), .REG_DATA_W(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .ares(ares), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .raddr(raddr_b),
    .rdata(rdata_b), .rbusy(rbusy_b), .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b), .wr_clash(wr_clash_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input reg_data_t got, input reg_data_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_a = '0; rsv_en_a = 1'b0;
    wen_b = '0; rsv_en_b = 1'b0;
  endtask

  initial begin
    ares = 1'b0;
    idle();
    waddr_a = '0; wdata_a = '0; raddr_a = '0; rsv_addr_a = '0;
    waddr_b = '0; wdata_b = '0; raddr_b = '0; rsv_addr_b = '0;
    repeat (2) @(posedge clk);
    #1 ares = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_rd_a%0d", i), rdata_a[i], 32'h0);
    chk("rst_rbusy_a", 32'(rbusy_a), 32'h0);
    chk("rst_clash_a", 32'(wr_clash_a), 32'h0);
    chk("rst_rbusy_b", 32'(rbusy_b), 32'h0);
    tick();

    // reset pulse in the middle of a write to r3
    wen_a = 2'b01; waddr_a[0] = 5'd3; wdata_a[0] = 32'hDEAD; raddr_a[0] = 5'd3;
    wen_b = 1'b1;  waddr_b    = 5'd3; wdata_b    = 32'hDEAD; raddr_b[0] = 5'd3;
    #1 chk("byp_pre_rst", rdata_a[0], 32'hDEAD);
    #1 ares = 1'b0;
    #1 chk("rst_held_rd", rdata_a[0], 32'h0);
    chk("rst_held_busy", 32'(rbusy_a), 32'h0);
    idle();
    #19 ares = 1'b1;
    #1 chk("rst_lost_a", rdata_a[0], 32'h0);
    chk("rst_lost_b", rdata_b[0], 32'h0);
    chk("rst_clash", 32'(wr_clash_a), 32'h0);
    tick();

    // write r5, bypass vs no bypass
    wen_a = 2'b01; waddr_a[0] = 5'd5; wdata_a[0] = 32'h1234; raddr_a[0] = 5'd5;
    wen_b = 1'b1;  waddr_b    = 5'd5; wdata_b    = 32'h1234; raddr_b[0] = 5'd5;
    #1 chk("wr_byp_a", rdata_a[0], 32'h1234);
    chk("wr_nobyp_b", rdata_b[0], 32'h0);
    tick(); idle();
    #1 chk("wr_stored_a", rdata_a[0], 32'h1234);
    chk("wr_stored_b", rdata_b[0], 32'h1234);

    // x0 writes on both ports plus x0 reservation
    raddr_a = '0;
    wen_a = 2'b11; waddr_a[0] = 5'd0; waddr_a[1] = 5'd0;
    wdata_a[0] = 32'hFFFF_FFFF; wdata_a[1] = 32'hFFFF_FFFF;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
    #1 for (int i = 0; i < 4; i++) chk($sformatf("x0_byp_rd%0d", i), rdata_a[i], 32'h0);
    chk("x0_byp_busy", 32'(rbusy_a), 32'h0);
    tick(); idle();
    #1 for (int i = 0; i < 4; i++) chk($sformatf("x0_rd%0d", i), rdata_a[i], 32'h0);
    chk("x0_busy", 32'(rbusy_a), 32'h0);
    chk("x0_noclash", 32'(wr_clash_a), 32'h0);

    // same-address collision on r7
    raddr_a[0] = 5'd7;
    wen_a = 2'b11; waddr_a[0] = 5'd7; waddr_a[1] = 5'd7;
    wdata_a[0] = 32'h11; wdata_a[1] = 32'h22;
    #1 chk("clash_byp", rdata_a[0], 32'h22);
    tick(); idle();
    #1 chk("clash_data", rdata_a[0], 32'h22);
    chk("clash_pulse", 32'(wr_clash_a), 32'h1);
    tick();
    chk("clash_gone", 32'(wr_clash_a), 32'h0);

    // scoreboard on r9
    raddr_a[0] = 5'd9; rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    raddr_b[0] = 5'd9; rsv_en_b = 1'b1; rsv_addr_b = 5'd9;
    #1 chk("sb_not_yet", 32'(rbusy_a[0]), 32'h0);
    tick(); idle();
    #1 chk("sb_set_a", 32'(rbusy_a[0]), 32'h1);
    chk("sb_set_b", 32'(rbusy_b[0]), 32'h1);
    wen_a = 2'b01; waddr_a[0] = 5'd9; wdata_a[0] = 32'hAB;
    wen_b = 1'b1;  waddr_b    = 5'd9; wdata_b    = 32'hAB;
    #1 chk("sb_byp_busy_a", 32'(rbusy_a[0]), 32'h0);
    chk("sb_byp_data_a", rdata_a[0], 32'hAB);
    chk("sb_nobyp_busy_b", 32'(rbusy_b[0]), 32'h1);
    chk("sb_nobyp_data_b", rdata_b[0], 32'h0);
    tick(); idle();
    #1 chk("sb_clr_a", 32'(rbusy_a[0]), 32'h0);
    chk("sb_clr_b", 32'(rbusy_b[0]), 32'h0);
    chk("sb_data_b", rdata_b[0], 32'hAB);
    rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    wen_a = 2'b01; waddr_a[0] = 5'd9; wdata_a[0] = 32'hCD;
    tick(); idle();
    #1 chk("sb_set_wins", 32'(rbusy_a[0]), 32'h1);
    chk("sb_set_data", rdata_a[0], 32'hCD);

    // four-port read of r1..r4
    wen_a = 2'b11; waddr_a[0] = 5'd1; waddr_a[1] = 5'd2; wdata_a[0] = 32'd1; wdata_a[1] = 32'd2;
    tick();
    waddr_a[0] = 5'd3; waddr_a[1] = 5'd4; wdata_a[0] = 32'd3; wdata_a[1] = 32'd4;
    #1 chk("mr_noclash", 32'(wr_clash_a), 32'h0);
    tick(); idle();
    raddr_a[0] = 5'd1; raddr_a[1] = 5'd2; raddr_a[2] = 5'd3; raddr_a[3] = 5'd4;
    #1 for (int i = 0; i < 4; i++) chk($sformatf("mr_rd%0d", i), rdata_a[i], reg_data_t'(i + 1));
    chk("mr_busy", 32'(rbusy_a), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
